// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-event monitor.
package perf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        FROZEN = 3'd2,
        DUMP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int EVT_INST  = 0;
    localparam int EVT_ICREQ = 1;
    localparam int EVT_ICHIT = 2;
    localparam int EVT_DCREQ = 3;
    localparam int EVT_DCHIT = 4;

endpackage

// File: rtl/perf_counter_cell.sv
// One CNT_W event counter with synchronous clear, saturate-or-wrap overflow
// behaviour and a sticky overflow flag.
module perf_counter_cell #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_reg;
    logic             ovf_reg;
    logic             at_max;

    assign at_max = &value_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                // Overflow is flagged in both modes; only the stored value differs.
                ovf_reg   <= 1'b1;
                value_reg <= (SATURATE != 0) ? value_reg : '0;
            end else begin
                value_reg <= value_reg + CNT_W'(1);
            end
        end
    end

    assign value = value_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/perf_event_monitor.sv
// Performance-event monitor: NUM_EVT event counters plus a run-cycle counter,
// counting between start and halt, then streaming all counts over a dump port.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    parameter int IDX_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt,
    input  logic               clear,
    input  logic [NUM_EVT-1:0] evt,
    output logic               running,
    output logic               frozen,
    output logic [NUM_EVT-1:0] ovf,
    output logic               cyc_ovf,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [IDX_W-1:0]   dump_idx,
    output logic [CNT_W-1:0]   dump_data,
    output logic               dump_last
);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             running_reg;
    logic             frozen_reg;
    logic             valid_reg;
    logic             last_reg;

    logic             counting;
    logic [NUM_EVT:0] inc_vec;
    logic [NUM_EVT:0] ovf_vec;
    logic [CNT_W-1:0] cnt_val [NUM_EVT+1];

    assign counting = (state_reg == RUN);
    // Top slot is the cycle counter; it ticks on every RUN cycle.
    assign inc_vec  = {counting, evt & {NUM_EVT{counting}}};

    generate
        for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
            perf_counter_cell #(
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .clr   (clear),
                .inc   (inc_vec[gi]),
                .value (cnt_val[gi]),
                .ovf   (ovf_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            running_reg <= 1'b0;
            frozen_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_reg   <= FROZEN;
                        running_reg <= 1'b0;
                        frozen_reg  <= 1'b1;
                    end
                end
                FROZEN: begin
                    state_reg <= DUMP;
                    idx_reg   <= '0;
                    valid_reg <= 1'b1;
                    last_reg  <= 1'b0;
                end
                DUMP: begin
                    // last is precomputed so the handshake only needs a register compare.
                    if (dump_ready) begin
                        if (last_reg) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            idx_reg   <= '0;
                        end else begin
                            idx_reg  <= idx_reg + IDX_W'(1);
                            last_reg <= (idx_reg == IDX_W'(NUM_EVT - 1));
                        end
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dump_data = '0;
        if (valid_reg) begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                if (idx_reg == IDX_W'(i)) begin
                    dump_data = cnt_val[i];
                end
            end
        end
    end

    assign running    = running_reg;
    assign frozen     = frozen_reg;
    assign ovf        = ovf_vec[NUM_EVT-1:0];
    assign cyc_ovf    = ovf_vec[NUM_EVT];
    assign cycle_cnt  = cnt_val[NUM_EVT];
    assign dump_valid = valid_reg;
    assign dump_idx   = idx_reg;
    assign dump_last  = last_reg;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor: a 32-bit instance plus two 8-bit
// instances (saturating and wrapping) sharing one stimulus stream.
module tb_perf_event_monitor;

    logic       clk = 1'b0;
    logic       rst, start, halt, clear, dump_ready;
    logic [3:0] evt;

    logic        m_running, m_frozen, m_cyc_ovf, m_dump_valid, m_dump_last;
    logic [3:0]  m_ovf;
    logic [31:0] m_cycle_cnt, m_dump_data;
    logic [4:0]  m_dump_idx;

    logic        s_running, s_frozen, s_cyc_ovf, s_dump_valid, s_dump_last;
    logic [3:0]  s_ovf;
    logic [7:0]  s_cycle_cnt, s_dump_data;
    logic [4:0]  s_dump_idx;

    logic        w_running, w_frozen, w_cyc_ovf, w_dump_valid, w_dump_last;
    logic [3:0]  w_ovf;
    logic [7:0]  w_cycle_cnt, w_dump_data;
    logic [4:0]  w_dump_idx;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_raw [5];

    always #5 clk = ~clk;

    perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .SATURATE(1), .IDX_W(5)) u_main (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear), .evt(evt),
        .running(m_running), .frozen(m_frozen), .ovf(m_ovf), .cyc_ovf(m_cyc_ovf),
        .cycle_cnt(m_cycle_cnt), .dump_valid(m_dump_valid), .dump_ready(dump_ready),
        .dump_idx(m_dump_idx), .dump_data(m_dump_data), .dump_last(m_dump_last)
    );

    perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .SATURATE(1), .IDX_W(5)) u_sat8 (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear), .evt(evt),
        .running(s_running), .frozen(s_frozen), .ovf(s_ovf), .cyc_ovf(s_cyc_ovf),
        .cycle_cnt(s_cycle_cnt), .dump_valid(s_dump_valid), .dump_ready(dump_ready),
        .dump_idx(s_dump_idx), .dump_data(s_dump_data), .dump_last(s_dump_last)
    );

    perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .SATURATE(0), .IDX_W(5)) u_wrap8 (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear), .evt(evt),
        .running(w_running), .frozen(w_frozen), .ovf(w_ovf), .cyc_ovf(w_cyc_ovf),
        .cycle_cnt(w_cycle_cnt), .dump_valid(w_dump_valid), .dump_ready(dump_ready),
        .dump_idx(w_dump_idx), .dump_data(w_dump_data), .dump_last(w_dump_last)
    );

    // Reference value of a counter that received 'raw' increments.
    function automatic longint model_val(input longint raw, input int w, input bit sat);
        longint lim;
        lim = (longint'(1) << w) - 1;
        if (raw <= lim) return raw;
        return sat ? lim : (raw % (lim + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; clear = 1'b0; evt = '0; dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Start from IDLE, run ncyc counted cycles (halt on the last), tally the model.
    task automatic run_session(input int ncyc, input bit rnd, input logic [3:0] fixed);
        for (int i = 0; i < 5; i++) exp_raw[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            evt  = rnd ? 4'($urandom) : fixed;
            halt = (c == ncyc - 1);
            for (int i = 0; i < 4; i++) exp_raw[i] += longint'(evt[i]);
            exp_raw[4]++;
            tick();
        end
        evt  = '0;
        halt = 1'b0;
    endtask

    // Drain the main dump port; mode 0: ready high, 1: ready 1-0-0-1, 2: random ready.
    task automatic test_dump_stream(input int mode);
        int          got, guard, hs;
        bit          stalled;
        logic [4:0]  prev_idx;
        logic [31:0] prev_data;
        got = 0; guard = 0; hs = 0; stalled = 1'b0;
        prev_idx = '0; prev_data = '0;
        while (!m_dump_valid && guard < 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!m_dump_valid) begin
            $display("FAIL dump_start_timeout: dump_valid=%0b required 1", m_dump_valid);
            n_fail++;
        end
        guard = 0;
        while (m_dump_valid && guard < 100) begin
            n_checks++;
            if (m_dump_idx !== 5'(got)) begin
                $display("FAIL dump_idx_order: idx=%0d required %0d", m_dump_idx, got);
                n_fail++;
            end
            n_checks++;
            if (m_dump_data !== 32'(exp_raw[got % 5])) begin
                $display("FAIL dump_data: entry %0d data=%0d required %0d", got, m_dump_data, exp_raw[got % 5]);
                n_fail++;
            end
            n_checks++;
            if (m_dump_last !== ((got == 4) ? 1'b1 : 1'b0)) begin
                $display("FAIL dump_last: entry %0d last=%0b required %0b", got, m_dump_last, (got == 4));
                n_fail++;
            end
            if (stalled) begin
                n_checks++;
                if (m_dump_idx !== prev_idx || m_dump_data !== prev_data) begin
                    $display("FAIL dump_stall_hold: idx=%0d data=%0d required idx=%0d data=%0d",
                             m_dump_idx, m_dump_data, prev_idx, prev_data);
                    n_fail++;
                end
            end
            case (mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = ((guard % 4) == 0) || ((guard % 4) == 3);
                default: dump_ready = 1'($urandom);
            endcase
            prev_idx  = m_dump_idx;
            prev_data = m_dump_data;
            stalled   = !dump_ready;
            if (dump_ready) begin
                $display("dump handshake idx=%0d data=%0d last=%0b", m_dump_idx, m_dump_data, m_dump_last);
                hs++;
                got++;
            end
            tick();
            guard++;
        end
        dump_ready = 1'b0;
        n_checks++;
        if (hs != 5) begin
            $display("FAIL dump_handshakes: count=%0d required 5", hs);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (m_dump_valid !== 1'b0 || m_frozen !== 1'b1 || m_running !== 1'b0) begin
                $display("FAIL dump_done_state: valid=%0b frozen=%0b running=%0b required 0/1/0",
                         m_dump_valid, m_frozen, m_running);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({m_running, m_frozen, m_ovf, m_cyc_ovf, m_dump_valid, m_dump_last} !== 9'd0 ||
            m_cycle_cnt !== 32'd0 || m_dump_idx !== 5'd0 || m_dump_data !== 32'd0) begin
            $display("FAIL reset_main: run=%0b frz=%0b ovf=%0h cyc=%0d valid=%0b idx=%0d data=%0d required all 0",
                     m_running, m_frozen, m_ovf, m_cycle_cnt, m_dump_valid, m_dump_idx, m_dump_data);
            n_fail++;
        end
        n_checks++;
        if ({s_running, s_frozen, s_ovf, s_cyc_ovf, s_dump_valid, s_cycle_cnt} !== 17'd0 ||
            {w_running, w_frozen, w_ovf, w_cyc_ovf, w_dump_valid, w_cycle_cnt} !== 17'd0) begin
            $display("FAIL reset_8bit: sat_cyc=%0d wrap_cyc=%0d sat_ovf=%0h wrap_ovf=%0h required 0",
                     s_cycle_cnt, w_cycle_cnt, s_ovf, w_ovf);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_session(10, 1'b0, 4'b0001);
        n_checks++;
        if (m_frozen !== 1'b1 || m_running !== 1'b0 || m_cycle_cnt !== 32'd10) begin
            $display("FAIL basic_halt: frozen=%0b running=%0b cycle_cnt=%0d required 1/0/10",
                     m_frozen, m_running, m_cycle_cnt);
            n_fail++;
        end
        test_dump_stream(0);
    endtask

    task automatic test_saturation();
        int k, guard;
        do_reset();
        for (int i = 0; i < 5; i++) exp_raw[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c == 255) begin
                n_checks++;
                if (w_cycle_cnt !== 8'd255 || w_ovf[2] !== 1'b0 || w_cyc_ovf !== 1'b0) begin
                    $display("FAIL wrap_before_ovf: cyc=%0d ovf2=%0b required 255/0", w_cycle_cnt, w_ovf[2]);
                    n_fail++;
                end
            end
            if (c == 256) begin
                n_checks++;
                if (w_cycle_cnt !== 8'd0 || w_ovf[2] !== 1'b1 || s_cycle_cnt !== 8'd255 || s_ovf[2] !== 1'b1) begin
                    $display("FAIL ovf_edge: wrap_cyc=%0d wrap_ovf2=%0b sat_cyc=%0d sat_ovf2=%0b required 0/1/255/1",
                             w_cycle_cnt, w_ovf[2], s_cycle_cnt, s_ovf[2]);
                    n_fail++;
                end
            end
            evt  = 4'b0100;
            halt = (c == 299);
            exp_raw[2]++;
            exp_raw[4]++;
            tick();
        end
        evt = '0;
        halt = 1'b0;
        dump_ready = 1'b1;
        guard = 0;
        while (!s_dump_valid && guard < 10) begin
            tick();
            guard++;
        end
        k = 0;
        guard = 0;
        while (s_dump_valid && guard < 20) begin
            n_checks++;
            if (s_dump_idx !== 5'(k) || s_dump_data !== 8'(model_val(exp_raw[k % 5], 8, 1'b1))) begin
                $display("FAIL sat_dump: idx=%0d data=%0d required idx=%0d data=%0d",
                         s_dump_idx, s_dump_data, k, model_val(exp_raw[k % 5], 8, 1'b1));
                n_fail++;
            end
            n_checks++;
            if (w_dump_idx !== 5'(k) || w_dump_data !== 8'(model_val(exp_raw[k % 5], 8, 1'b0))) begin
                $display("FAIL wrap_dump: idx=%0d data=%0d required idx=%0d data=%0d",
                         w_dump_idx, w_dump_data, k, model_val(exp_raw[k % 5], 8, 1'b0));
                n_fail++;
            end
            $display("dump8 idx=%0d sat=%0d wrap=%0d", s_dump_idx, s_dump_data, w_dump_data);
            k++;
            tick();
            guard++;
        end
        dump_ready = 1'b0;
        n_checks++;
        if (k != 5) begin
            $display("FAIL dump8_entries: count=%0d required 5", k);
            n_fail++;
        end
        n_checks++;
        if (s_ovf !== 4'b0100 || w_ovf !== 4'b0100 || s_cyc_ovf !== 1'b1 || w_cyc_ovf !== 1'b1 ||
            m_ovf !== 4'b0000 || m_cyc_ovf !== 1'b0) begin
            $display("FAIL ovf_flags: sat=%0h/%0b wrap=%0h/%0b main=%0h/%0b required 4/1 4/1 0/0",
                     s_ovf, s_cyc_ovf, w_ovf, w_cyc_ovf, m_ovf, m_cyc_ovf);
            n_fail++;
        end
    endtask

    task automatic test_ready_stall();
        do_clear();
        run_session(15, 1'b1, 4'b0000);
        test_dump_stream(1);
    endtask

    task automatic test_ignored_inputs();
        do_clear();
        for (int c = 0; c < 5; c++) begin
            evt  = 4'($urandom) | 4'b0001;
            halt = 1'b1;
            tick();
        end
        evt = '0;
        halt = 1'b0;
        n_checks++;
        if (m_running !== 1'b0 || m_frozen !== 1'b0 || m_cycle_cnt !== 32'd0) begin
            $display("FAIL idle_ignore: running=%0b frozen=%0b cyc=%0d required 0/0/0",
                     m_running, m_frozen, m_cycle_cnt);
            n_fail++;
        end
        run_session(6, 1'b1, 4'b0000);
        start = 1'b1;
        tick();
        tick();
        n_checks++;
        if (m_dump_valid !== 1'b1 || m_dump_idx !== 5'd0 || m_running !== 1'b0) begin
            $display("FAIL start_in_dump: valid=%0b idx=%0d running=%0b required 1/0/0",
                     m_dump_valid, m_dump_idx, m_running);
            n_fail++;
        end
        start = 1'b0;
        test_dump_stream(2);
        for (int c = 0; c < 4; c++) begin
            evt   = 4'($urandom);
            start = 1'($urandom);
            halt  = 1'($urandom);
            tick();
        end
        evt = '0; start = 1'b0; halt = 1'b0;
        n_checks++;
        if (m_frozen !== 1'b1 || m_running !== 1'b0 || m_dump_valid !== 1'b0 ||
            m_cycle_cnt !== 32'(exp_raw[4])) begin
            $display("FAIL done_ignore: frozen=%0b running=%0b valid=%0b cyc=%0d required 1/0/0/%0d",
                     m_frozen, m_running, m_dump_valid, m_cycle_cnt, exp_raw[4]);
            n_fail++;
        end
    endtask

    // Abort a dump mid-stream with clear (use_rst=0) or rst (use_rst=1).
    task automatic test_abort(input bit use_rst, input int at_idx);
        int guard;
        do_clear();
        run_session(20, 1'b1, 4'b0000);
        dump_ready = 1'b1;
        guard = 0;
        while (!(m_dump_valid && m_dump_idx == 5'(at_idx)) && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (m_dump_idx !== 5'(at_idx) || m_dump_valid !== 1'b1) begin
            $display("FAIL abort_reach_idx: idx=%0d valid=%0b required %0d/1", m_dump_idx, m_dump_valid, at_idx);
            n_fail++;
        end
        if (use_rst) rst = 1'b1;
        else clear = 1'b1;
        tick();
        rst = 1'b0;
        clear = 1'b0;
        dump_ready = 1'b0;
        $display("dump aborted at idx=%0d by %s", at_idx, use_rst ? "rst" : "clear");
        n_checks++;
        if (m_running !== 1'b0 || m_frozen !== 1'b0 || m_dump_valid !== 1'b0 || m_dump_idx !== 5'd0 ||
            m_dump_data !== 32'd0 || m_dump_last !== 1'b0 || m_ovf !== 4'd0 || m_cyc_ovf !== 1'b0 ||
            m_cycle_cnt !== 32'd0) begin
            $display("FAIL abort_state: run=%0b frz=%0b valid=%0b idx=%0d data=%0d cyc=%0d required all 0",
                     m_running, m_frozen, m_dump_valid, m_dump_idx, m_dump_data, m_cycle_cnt);
            n_fail++;
        end
        run_session(1, 1'b0, 4'b0000);
        test_dump_stream(0);
    endtask

    task automatic test_start_halt_same();
        do_clear();
        start = 1'b1;
        halt  = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        n_checks++;
        if (m_running !== 1'b1 || m_frozen !== 1'b0 || m_cycle_cnt !== 32'd0) begin
            $display("FAIL start_halt_same: running=%0b frozen=%0b cyc=%0d required 1/0/0",
                     m_running, m_frozen, m_cycle_cnt);
            n_fail++;
        end
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        n_checks++;
        if (m_cycle_cnt !== 32'd3 || m_frozen !== 1'b1 || m_running !== 1'b0) begin
            $display("FAIL later_halt: cyc=%0d frozen=%0b running=%0b required 3/1/0",
                     m_cycle_cnt, m_frozen, m_running);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 4; s++) begin
            do_clear();
            run_session(int'($urandom_range(1, 40)), 1'b1, 4'b0000);
            test_dump_stream(2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; clear = 1'b0; evt = '0; dump_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_ready_stall();
        test_ignored_inputs();
        test_abort(1'b0, 2);
        test_abort(1'b1, 1);
        test_start_halt_same();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
